// File: rtl/accelerator_pkg.sv
// Shared types for the vector sequencer: FSM state encoding and the
// element-width to register-step mapping.
package accelerator_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RETIRE = 2'd2
    } seq_state_t;

    localparam logic [1:0]  SEW_E8       = 2'd0;
    localparam logic [1:0]  SEW_E16      = 2'd1;
    localparam logic [1:0]  SEW_E32      = 2'd2;
    localparam int unsigned SEW_STEP_DIV = 4;

    function automatic logic [1:0] sew_shift(input logic [1:0] vsew);
        logic [1:0] sh;
        case (vsew)
            SEW_E8:  sh = 2'd0;
            SEW_E16: sh = 2'd1;
            SEW_E32: sh = 2'd2;
            default: sh = 2'd2;  // reserved encoding runs as 32-bit
        endcase
        return sh;
    endfunction

    // Registers consumed per beat, modulo the 32-entry register file.
    function automatic logic [4:0] reg_step(input int unsigned lanes, input logic [1:0] vsew);
        int unsigned regs;
        regs = (lanes << sew_shift(vsew)) / SEW_STEP_DIV;
        return regs[4:0];
    endfunction

endpackage

// File: rtl/vector_sequencer_if.sv
// APU-side request/retire handshake and per-beat sequencer output bundle.
interface vector_sequencer_if #(
    parameter int NUM_LANES = 4,
    parameter int VL_W      = 6
);
    logic                 apu_req;
    logic                 apu_gnt;
    logic [31:0]          apu_instr;
    logic                 apu_multi;
    logic                 apu_fix_addr;
    logic [VL_W-1:0]      vl;
    logic [1:0]           vsew;
    logic                 stall_i;
    logic                 seq_valid;
    logic [31:0]          seq_instr;
    logic [4:0]           seq_vs1_addr;
    logic [4:0]           seq_vs2_addr;
    logic [4:0]           seq_vd_addr;
    logic                 seq_first;
    logic                 seq_last;
    logic [NUM_LANES-1:0] seq_elem_mask;
    logic                 apu_rvalid;
    logic                 busy;

    modport master (
        output apu_req, apu_instr, apu_multi, apu_fix_addr, vl, vsew, stall_i,
        input  apu_gnt, seq_valid, seq_instr, seq_vs1_addr, seq_vs2_addr, seq_vd_addr,
               seq_first, seq_last, seq_elem_mask, apu_rvalid, busy
    );

    modport slave (
        input  apu_req, apu_instr, apu_multi, apu_fix_addr, vl, vsew, stall_i,
        output apu_gnt, seq_valid, seq_instr, seq_vs1_addr, seq_vs2_addr, seq_vd_addr,
               seq_first, seq_last, seq_elem_mask, apu_rvalid, busy
    );

endinterface

// File: rtl/vector_instr_fifo.sv
// Small power-of-two instruction queue; a push into a full queue is taken
// when a pop happens in the same cycle.
module vector_instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/vector_sequencer.sv
// Splits accepted vector instructions into per-beat register/lane slices.
// VECTOR_SEQUENCER_PREFETCH_EN adds an instruction queue filled while busy.
//
// state  | meaning
// IDLE   | no beat in flight; a zero-length instruction waits here one cycle
// ISSUE  | presenting beat beat_q of the current instruction
// RETIRE | one-cycle apu_rvalid pulse; may load the next instruction
module vector_sequencer
    import accelerator_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int VL_W        = 6,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    vector_sequencer_if.slave bus
);
    localparam int              LANE_SH  = $clog2(NUM_LANES);
    localparam logic [VL_W-1:0] BEAT_ONE = VL_W'(1);

    typedef struct packed {
        logic [31:0]     instr;
        logic            multi;
        logic            fix;
        logic [1:0]      vsew;
        logic [VL_W-1:0] vl;
    } entry_t;

    if (NUM_LANES < 4 || (NUM_LANES & (NUM_LANES - 1)) != 0) begin : g_bad_lanes
        $error("NUM_LANES must be a power of two, at least 4");
    end
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("QUEUE_DEPTH must be a power of two, at least 2");
    end

    function automatic logic [VL_W-1:0] beat_count(input entry_t e);
        int unsigned rounded;
        rounded = (32'(e.vl) + 32'(NUM_LANES) - 32'd1) >> LANE_SH;
        return e.multi ? VL_W'(rounded) : BEAT_ONE;
    endfunction

    seq_state_t      state_q, state_d;
    entry_t          cur_q, cur_d, acc_ent, load_ent;
    logic [VL_W-1:0] beat_q, beat_d, beats_q, beats_d;
    logic [4:0]      step_q, step_d;
    logic            zero_q, zero_d, rdy_q;
    logic            accept, load, q_busy;

    logic                 seq_valid_d, seq_valid_q;
    logic [31:0]          seq_instr_d, seq_instr_q;
    logic [4:0]           vs1_d, vs1_q, vs2_d, vs2_q, vd_d, vd_q, off;
    logic                 first_d, first_q, last_d, last_q;
    logic [NUM_LANES-1:0] mask_d, mask_q;

    assign accept  = bus.apu_req && bus.apu_gnt;
    assign acc_ent = {bus.apu_instr, bus.apu_multi, bus.apu_fix_addr, bus.vsew, bus.vl};

`ifdef VECTOR_SEQUENCER_PREFETCH_EN
    logic   free_slot, fifo_empty, fifo_full, fifo_pop, fifo_push, direct;
    entry_t fifo_rdata;

    // Queue head has priority; an empty queue lets the request bypass it.
    assign free_slot   = ((state_q == S_IDLE) && !zero_q) || (state_q == S_RETIRE);
    assign fifo_pop    = free_slot && !fifo_empty;
    assign direct      = free_slot && fifo_empty && accept;
    assign fifo_push   = accept && !direct;
    assign load        = fifo_pop || direct;
    assign load_ent    = fifo_pop ? fifo_rdata : acc_ent;
    assign bus.apu_gnt = rdy_q && (!fifo_full || fifo_pop);
    assign q_busy      = !fifo_empty;

    vector_instr_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (acc_ent),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );
`else
    assign load        = accept;
    assign load_ent    = acc_ent;
    assign bus.apu_gnt = rdy_q && (state_q == S_IDLE) && !zero_q;
    assign q_busy      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        beat_d  = beat_q;
        beats_d = beats_q;
        step_d  = step_q;
        zero_d  = zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (zero_q) begin
                    state_d = S_RETIRE;
                    zero_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                if (!bus.stall_i) begin
                    if (beat_q == beats_q - BEAT_ONE) state_d = S_RETIRE;
                    else                              beat_d  = beat_q + BEAT_ONE;
                end
            end
            S_RETIRE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (load) begin
            cur_d   = load_ent;
            beat_d  = '0;
            beats_d = beat_count(load_ent);
            step_d  = load_ent.fix ? 5'd0 : reg_step(NUM_LANES, load_ent.vsew);
            if (beats_d != '0) begin
                state_d = S_ISSUE;
            end else begin
                state_d = S_IDLE;
                zero_d  = 1'b1;
            end
        end
    end

    // Beat outputs are computed from next state so they are registered yet
    // appear the cycle after accept; a stall leaves every input unchanged.
    always_comb begin
        seq_valid_d = (state_d == S_ISSUE);
        seq_instr_d = '0;
        vs1_d       = '0;
        vs2_d       = '0;
        vd_d        = '0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        mask_d      = '0;
        off         = 5'(32'(beat_d) * 32'(step_d));
        if (seq_valid_d) begin
            seq_instr_d = cur_d.instr;
            vs1_d       = cur_d.instr[19:15] + off;
            vs2_d       = cur_d.instr[24:20] + off;
            vd_d        = cur_d.instr[11:7] + off;
            first_d     = (beat_d == '0);
            last_d      = (beat_d == beats_d - BEAT_ONE);
            for (int i = 0; i < NUM_LANES; i++) begin
                mask_d[i] = !cur_d.multi ||
                            (((32'(beat_d) << LANE_SH) + 32'(i)) < 32'(cur_d.vl));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            beat_q      <= '0;
            beats_q     <= '0;
            step_q      <= '0;
            zero_q      <= 1'b0;
            rdy_q       <= 1'b0;
            seq_valid_q <= 1'b0;
            seq_instr_q <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            vd_q        <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            beat_q      <= beat_d;
            beats_q     <= beats_d;
            step_q      <= step_d;
            zero_q      <= zero_d;
            rdy_q       <= 1'b1;
            seq_valid_q <= seq_valid_d;
            seq_instr_q <= seq_instr_d;
            vs1_q       <= vs1_d;
            vs2_q       <= vs2_d;
            vd_q        <= vd_d;
            first_q     <= first_d;
            last_q      <= last_d;
            mask_q      <= mask_d;
        end
    end

    assign bus.seq_valid     = seq_valid_q;
    assign bus.seq_instr     = seq_instr_q;
    assign bus.seq_vs1_addr  = vs1_q;
    assign bus.seq_vs2_addr  = vs2_q;
    assign bus.seq_vd_addr   = vd_q;
    assign bus.seq_first     = first_q;
    assign bus.seq_last      = last_q;
    assign bus.seq_elem_mask = mask_q;
    assign bus.apu_rvalid    = (state_q == S_RETIRE);
    assign bus.busy          = (state_q != S_IDLE) || zero_q || q_busy;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer with hand-computed expected beats.
module tb_vector_sequencer;
    localparam int NL = 4;
    localparam int VW = 6;
    localparam int QD = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    vector_sequencer_if #(.NUM_LANES(NL), .VL_W(VW)) bus ();

    vector_sequencer #(
        .NUM_LANES   (NL),
        .VL_W        (VW),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] vs2, input logic [4:0] vs1,
                                             input logic [4:0] vd);
        return {7'b0, vs2, vs1, 3'b000, vd, 7'h57};
    endfunction

    task automatic offer(input logic [31:0] instr, input logic multi, input logic fix,
                         input logic [5:0] vl, input logic [1:0] vsew);
        bus.apu_instr    = instr;
        bus.apu_multi    = multi;
        bus.apu_fix_addr = fix;
        bus.vl           = vl;
        bus.vsew         = vsew;
        bus.apu_req      = 1'b1;
    endtask

    // Returns in the first cycle after the accept cycle.
    task automatic send(input logic [31:0] instr, input logic multi, input logic fix,
                        input logic [5:0] vl, input logic [1:0] vsew);
        int k = 0;
        offer(instr, multi, fix, vl, vsew);
        while (bus.apu_gnt !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("gnt_wait", 32'(bus.apu_gnt), 32'd1);
        tick();
        bus.apu_req = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] instr, input int vs1,
                              input int vs2, input int vd, input int mask,
                              input int first, input int last);
        check({tag, "_valid"}, 32'(bus.seq_valid), 32'd1);
        check({tag, "_instr"}, bus.seq_instr, instr);
        check({tag, "_vs1"}, 32'(bus.seq_vs1_addr), 32'(vs1));
        check({tag, "_vs2"}, 32'(bus.seq_vs2_addr), 32'(vs2));
        check({tag, "_vd"}, 32'(bus.seq_vd_addr), 32'(vd));
        check({tag, "_mask"}, 32'(bus.seq_elem_mask), 32'(mask));
        check({tag, "_first"}, 32'(bus.seq_first), 32'(first));
        check({tag, "_last"}, 32'(bus.seq_last), 32'(last));
        check({tag, "_rv"}, 32'(bus.apu_rvalid), 32'd0);
    endtask

    task automatic check_retire(input string tag);
        check({tag, "_rvalid"}, 32'(bus.apu_rvalid), 32'd1);
        check({tag, "_novalid"}, 32'(bus.seq_valid), 32'd0);
        tick();
        check({tag, "_rv_low"}, 32'(bus.apu_rvalid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ia, ib, ic;
        bus.apu_req      = 1'b0;
        bus.apu_instr    = '0;
        bus.apu_multi    = 1'b0;
        bus.apu_fix_addr = 1'b0;
        bus.vl           = '0;
        bus.vsew         = '0;
        bus.stall_i      = 1'b0;

        reset = 1'b1;
        repeat (3) tick();
        check("rst_gnt", 32'(bus.apu_gnt), 32'd0);
        check("rst_valid", 32'(bus.seq_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rvalid", 32'(bus.apu_rvalid), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_gnt", 32'(bus.apu_gnt), 32'd1);

        // vl=10, e8: 3 beats, step 1, tail mask 0011, rvalid 4 cycles after accept
        ia = mk_instr(5'd8, 5'd2, 5'd4);
        send(ia, 1'b1, 1'b0, 6'd10, 2'd0);
        check_beat("b27_0", ia, 2, 8, 4, 'hF, 1, 0); tick();
        check_beat("b27_1", ia, 3, 9, 5, 'hF, 0, 0); tick();
        check_beat("b27_2", ia, 4, 10, 6, 'h3, 0, 1); tick();
        check_retire("b27");
        check("b27_idle_busy", 32'(bus.busy), 32'd0);

        // e16: step 2; 3 stall cycles on the second beat
        send(ia, 1'b1, 1'b0, 6'd10, 2'd1);
        check_beat("b28_0", ia, 2, 8, 4, 'hF, 1, 0); tick();
        check_beat("b28_1", ia, 4, 10, 6, 'hF, 0, 0);
        bus.stall_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check_beat("b28_hold", ia, 4, 10, 6, 'hF, 0, 0);
        end
        bus.stall_i = 1'b0;
        tick();
        check_beat("b28_2", ia, 6, 12, 8, 'h3, 0, 1); tick();
        check_retire("b28");

        // vl=0 multi: no beat, rvalid 2 cycles after accept
        send(mk_instr(5'd1, 5'd1, 5'd1), 1'b1, 1'b0, 6'd0, 2'd0);
        check("z_valid", 32'(bus.seq_valid), 32'd0);
        check("z_rv_early", 32'(bus.apu_rvalid), 32'd0);
        check("z_busy", 32'(bus.busy), 32'd1);
        tick();
        check_retire("z");
        check("z_gnt", 32'(bus.apu_gnt), 32'd1);

        // fixed addresses
        ia = mk_instr(5'd0, 5'd3, 5'd0);
        send(ia, 1'b1, 1'b1, 6'd8, 2'd0);
        check_beat("fix_0", ia, 3, 0, 0, 'hF, 1, 0); tick();
        check_beat("fix_1", ia, 3, 0, 0, 'hF, 0, 1); tick();
        check_retire("fix");

        // vd wraps 31 -> 0
        ia = mk_instr(5'd0, 5'd0, 5'd31);
        send(ia, 1'b1, 1'b0, 6'd8, 2'd0);
        check_beat("wrap_0", ia, 0, 0, 31, 'hF, 1, 0); tick();
        check_beat("wrap_1", ia, 1, 1, 0, 'hF, 0, 1); tick();
        check_retire("wrap");

        // single beat: vl ignored, full mask, first and last together
        ia = mk_instr(5'd5, 5'd6, 5'd7);
        send(ia, 1'b0, 1'b0, 6'd5, 2'd2);
        check_beat("one", ia, 6, 5, 7, 'hF, 1, 1); tick();
        check_retire("one");

        // vsew=3 behaves as e32: step 4
        ia = mk_instr(5'd0, 5'd0, 5'd1);
        send(ia, 1'b1, 1'b0, 6'd12, 2'd3);
        check_beat("sew3_0", ia, 0, 0, 1, 'hF, 1, 0); tick();
        check_beat("sew3_1", ia, 4, 4, 5, 'hF, 0, 0); tick();
        check_beat("sew3_2", ia, 8, 8, 9, 'hF, 0, 1); tick();
        check_retire("sew3");

        // back-to-back requests
        ia = mk_instr(5'd10, 5'd11, 5'd12);
        ib = mk_instr(5'd13, 5'd14, 5'd15);
        ic = mk_instr(5'd16, 5'd17, 5'd18);
`ifdef VECTOR_SEQUENCER_PREFETCH_EN
        offer(ia, 1'b1, 1'b0, 6'd12, 2'd0);
        check("q_gnt_a", 32'(bus.apu_gnt), 32'd1);
        tick();
        offer(ib, 1'b0, 1'b0, 6'd0, 2'd0);
        check("q_gnt_b", 32'(bus.apu_gnt), 32'd1);
        check("q_a_valid", 32'(bus.seq_valid), 32'd1);
        tick();
        offer(ic, 1'b0, 1'b0, 6'd0, 2'd0);
        check("q_gnt_c", 32'(bus.apu_gnt), 32'd1);
        tick();
        bus.apu_req = 1'b0;
        check("q_gnt_full", 32'(bus.apu_gnt), 32'd0);
        check("q_a_last", 32'(bus.seq_last), 32'd1);
        tick();
        check("q_rv_a", 32'(bus.apu_rvalid), 32'd1);
        tick();
        check_beat("q_b", ib, 14, 13, 15, 'hF, 1, 1);
        tick();
        check("q_rv_b", 32'(bus.apu_rvalid), 32'd1);
        tick();
        check_beat("q_c", ic, 17, 16, 18, 'hF, 1, 1);
        tick();
        check("q_rv_c", 32'(bus.apu_rvalid), 32'd1);
        tick();
        check("q_busy_end", 32'(bus.busy), 32'd0);
`else
        send(ia, 1'b1, 1'b0, 6'd12, 2'd0);
        offer(ib, 1'b0, 1'b0, 6'd0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            check("nq_gnt_low", 32'(bus.apu_gnt), 32'd0);
            tick();
        end
        check("nq_gnt_idle", 32'(bus.apu_gnt), 32'd1);
        tick();
        bus.apu_req = 1'b0;
        check_beat("nq_b", ib, 14, 13, 15, 'hF, 1, 1);
        tick();
        check_retire("nq_b");
`endif

        // reset during the second beat aborts with no rvalid
        ia = mk_instr(5'd2, 5'd2, 5'd2);
        send(ia, 1'b1, 1'b0, 6'd12, 2'd0);
        check_beat("ab_0", ia, 2, 2, 2, 'hF, 1, 0); tick();
        check_beat("ab_1", ia, 3, 3, 3, 'hF, 0, 0);
        reset = 1'b1;
        tick();
        check("ab_valid", 32'(bus.seq_valid), 32'd0);
        check("ab_busy", 32'(bus.busy), 32'd0);
        check("ab_rv", 32'(bus.apu_rvalid), 32'd0);
        reset = 1'b0;
        tick();
        check("ab_rv_after", 32'(bus.apu_rvalid), 32'd0);
        check("ab_gnt_after", 32'(bus.apu_gnt), 32'd1);
        tick();
        check("ab_rv_later", 32'(bus.apu_rvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
